// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined barrel shifter / rotator (SLL, SRL, SRA, ROR).
// One log-shift stage per register; stage k shifts by 2^k when shamt bit k
// is set. The last stage is the output register, with zero/negative flags
// registered alongside the result. Whole pipe freezes while the output is
// stalled; flush drops every in-flight operation.
module shifter_pipe #(
   parameter  int WIDTH = 16,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zr,
   output logic             out_neg
);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   // One fixed-distance shift/rotate step; s is a per-stage constant.
   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d,
                                             input logic [1:0]       op,
                                             input logic             sgn,
                                             input int               s);
      logic [WIDTH-1:0] fill;
      fill = sgn ? ~({WIDTH{1'b1}} >> s) : '0;
      case (op)
         OP_SLL:  step = d << s;
         OP_SRL:  step = d >> s;
         OP_SRA:  step = (d >> s) | fill;
         default: step = (d >> s) | (d << (WIDTH - s));
      endcase
   endfunction

   // Stage registers. Metadata is only needed by downstream stages, so the
   // output stage keeps just data and valid.
   logic [WIDTH-1:0] data_q  [SHW];
   logic             vld_q   [SHW];
   logic [SHW-1:0]   shamt_q [SHW-1];
   logic [1:0]       op_q    [SHW-1];
   logic             sign_q  [SHW-1];

   // Stage inputs and per-stage next data.
   logic [WIDTH-1:0] src_data  [SHW];
   logic [SHW-1:0]   src_shamt [SHW];
   logic [1:0]       src_op    [SHW];
   logic             src_sign  [SHW];
   logic             src_vld   [SHW];
   logic [WIDTH-1:0] nxt_data  [SHW];

   logic stall;

   assign stall     = vld_q[SHW-1] && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = vld_q[SHW-1];
   assign out_data  = data_q[SHW-1];

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      if (k == 0) begin : g_head
         // Sign is captured at accept and carried with the operation.
         assign src_data[k]  = in_data;
         assign src_shamt[k] = in_shamt;
         assign src_op[k]    = in_op;
         assign src_sign[k]  = in_data[WIDTH-1];
         assign src_vld[k]   = in_valid;
      end else begin : g_chain
         assign src_data[k]  = data_q[k-1];
         assign src_shamt[k] = shamt_q[k-1];
         assign src_op[k]    = op_q[k-1];
         assign src_sign[k]  = sign_q[k-1];
         assign src_vld[k]   = vld_q[k-1];
      end
      assign nxt_data[k] = src_shamt[k][k]
                         ? step(src_data[k], src_op[k], src_sign[k], 1 << k)
                         : src_data[k];
   end

   // Advance all stages together unless stalled; flush kills every valid bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < SHW; k++) begin
            data_q[k] <= '0;
            vld_q[k]  <= 1'b0;
         end
         for (int k = 0; k < SHW - 1; k++) begin
            shamt_q[k] <= '0;
            op_q[k]    <= '0;
            sign_q[k]  <= 1'b0;
         end
      end else begin
         if (!stall) begin
            for (int k = 0; k < SHW; k++) begin
               data_q[k] <= nxt_data[k];
               vld_q[k]  <= src_vld[k];
            end
            for (int k = 0; k < SHW - 1; k++) begin
               shamt_q[k] <= src_shamt[k];
               op_q[k]    <= src_op[k];
               sign_q[k]  <= src_sign[k];
            end
         end
         if (flush) begin
            for (int k = 0; k < SHW; k++) vld_q[k] <= 1'b0;
         end
      end
   end

   // Flags come from the final-stage result so they load with out_data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_zr  <= 1'b0;
         out_neg <= 1'b0;
      end else if (!stall) begin
         out_zr  <= (nxt_data[SHW-1] == '0);
         out_neg <= nxt_data[SHW-1][WIDTH-1];
      end
   end

endmodule

// File: tb/tb_shifter_pipe.sv
// tb_shifter_pipe: table vectors, random streams with stall, flush and
// asynchronous reset sequences for WIDTH=16, plus a WIDTH=32 latency check.
module tb_shifter_pipe;

   localparam int W  = 16;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst, flush;
   logic          in_valid, in_ready, out_valid, out_ready, out_zr, out_neg;
   logic [W-1:0]  in_data, out_data;
   logic [SW-1:0] in_shamt;
   logic [1:0]    in_op;

   logic          flush32, in_valid32, in_ready32, out_valid32, out_ready32;
   logic          out_zr32, out_neg32;
   logic [31:0]   in_data32, out_data32;
   logic [4:0]    in_shamt32;
   logic [1:0]    in_op32;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shifter_pipe #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_shamt(in_shamt), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_zr(out_zr), .out_neg(out_neg)
   );

   shifter_pipe #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .flush(flush32),
      .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32),
      .in_shamt(in_shamt32), .in_op(in_op32),
      .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32),
      .out_zr(out_zr32), .out_neg(out_neg32)
   );

   typedef struct {
      logic [15:0] d;
      logic [3:0]  sh;
      logic [1:0]  op;
      logic [15:0] exp;
      logic        zr;
      logic        neg;
   } vec_t;

   vec_t vecs[8];

   // Reference: whole-amount shift/rotate straight from the operation rules.
   function automatic logic [15:0] ref16(input logic [15:0] d, input int n,
                                         input logic [1:0] op);
      logic signed [15:0] s;
      logic [31:0]        dd;
      s  = d;
      dd = {d, d} >> n;
      case (op)
         2'b00:   return d << n;
         2'b01:   return d >> n;
         2'b10:   return s >>> n;
         default: return dd[15:0];
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One isolated operation: checks latency in edges, result and flags.
   task automatic run_one(input string nm, input logic [15:0] d, input logic [3:0] sh,
                          input logic [1:0] op, input logic [15:0] ed,
                          input logic ez, input logic en);
      int lat;
      bit seen;
      @(negedge clk);
      in_data = d; in_shamt = sh; in_op = op; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1; seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) begin seen = 1; break; end
         @(posedge clk);
         lat++;
      end
      chk({nm, " result seen"}, 64'(seen), 64'd1);
      if (seen) begin
         chk({nm, " latency"}, 64'(lat), 64'd4);
         chk({nm, " data"}, 64'(out_data), 64'(ed));
         chk({nm, " zr"}, 64'(out_zr), 64'(ez));
         chk({nm, " neg"}, 64'(out_neg), 64'(en));
      end
   endtask

   // Random back-to-back stream against a queue scoreboard; optional 3-cycle stall.
   task automatic stream(input int nops, input bit do_stall);
      logic [15:0] q_d[$];
      int sent, got, stalls, extra;
      bit acc;
      sent = 0; got = 0; stalls = 0; acc = 0; extra = 0;
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 400 && got < nops; cyc++) begin
         @(negedge clk);
         if (acc || !in_valid) begin
            if (sent < nops) begin
               in_data = 16'($urandom); in_shamt = 4'($urandom);
               in_op = 2'($urandom); in_valid = 1'b1;
            end else in_valid = 1'b0;
         end
         acc = 0;
         out_ready = !(do_stall && out_valid && stalls < 3);
         if (!out_ready) stalls++;
         #1;
         chk("in_ready vs stall", 64'(in_ready), 64'(out_ready || !out_valid));
         if (out_valid) begin
            if (q_d.size() == 0) chk("unexpected result", 64'd1, 64'd0);
            else begin
               chk("stream data", 64'(out_data), 64'(q_d[0]));
               chk("stream zr", 64'(out_zr), 64'(q_d[0] == 16'h0));
               chk("stream neg", 64'(out_neg), 64'(q_d[0][15]));
               if (out_ready) begin void'(q_d.pop_front()); got++; end
            end
         end
         if (in_valid && in_ready) begin
            q_d.push_back(ref16(in_data, int'(in_shamt), in_op));
            sent++; acc = 1;
         end
      end
      chk("stream result count", 64'(got), 64'(nops));
      if (do_stall) chk("stall cycles", 64'(stalls), 64'd3);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      chk("no duplicate results", 64'(extra), 64'd0);
   endtask

   initial begin
      int lat, extra;
      bit seen;
      vecs[0] = '{16'h1234, 4'd4,  2'b00, 16'h2340, 1'b0, 1'b0};
      vecs[1] = '{16'h8001, 4'd15, 2'b10, 16'hFFFF, 1'b0, 1'b1};
      vecs[2] = '{16'h8001, 4'd15, 2'b01, 16'h0001, 1'b0, 1'b0};
      vecs[3] = '{16'h7FFF, 4'd3,  2'b10, 16'h0FFF, 1'b0, 1'b0};
      vecs[4] = '{16'h0001, 4'd1,  2'b11, 16'h8000, 1'b0, 1'b1};
      vecs[5] = '{16'hABCD, 4'd0,  2'b11, 16'hABCD, 1'b0, 1'b1};
      vecs[6] = '{16'h8000, 4'd1,  2'b00, 16'h0000, 1'b1, 1'b0};
      vecs[7] = '{16'h1234, 4'd12, 2'b11, 16'h2341, 1'b0, 1'b0};

      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_data = '0; in_shamt = '0; in_op = '0;
      flush32 = 1'b0; in_valid32 = 1'b0; out_ready32 = 1'b1;
      in_data32 = '0; in_shamt32 = '0; in_op32 = '0;

      // Reset state
      #1 rst = 1'b1;
      #1;
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset out_data", 64'(out_data), 64'd0);
      chk("reset out_zr", 64'(out_zr), 64'd0);
      chk("reset out_neg", 64'(out_neg), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 chk("in_ready after reset", 64'(in_ready), 64'd1);

      // Directed vectors
      for (int i = 0; i < 8; i++)
         run_one($sformatf("vec%0d", i), vecs[i].d, vecs[i].sh, vecs[i].op,
                 vecs[i].exp, vecs[i].zr, vecs[i].neg);

      // Random streams, with and without backpressure
      stream(8, 1'b1);
      stream(40, 1'b0);

      // Flush with 3 in flight and a fourth presented on the flush edge
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 16'($urandom); in_shamt = 4'($urandom); in_op = 2'($urandom);
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_data = 16'hFFFF; in_shamt = 4'd0; in_op = 2'b00; flush = 1'b1;
      #1 chk("in_ready during flush", 64'(in_ready), 64'd1);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("out_valid after flush", 64'(out_valid), 64'd0);
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      chk("flushed results emerge", 64'(extra), 64'd0);
      run_one("post-flush", 16'h00F0, 4'd4, 2'b01, 16'h000F, 1'b0, 1'b0);

      // Asynchronous reset between edges with results in flight
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         in_data = 16'h8000 | 16'($urandom); in_shamt = 4'd0; in_op = 2'b00;
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("pre-reset out_valid", 64'(out_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("async reset out_valid", 64'(out_valid), 64'd0);
      chk("async reset out_data", 64'(out_data), 64'd0);
      chk("async reset out_neg", 64'(out_neg), 64'd0);
      #1 rst = 1'b0;
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      chk("stale after reset", 64'(extra), 64'd0);
      chk("in_ready after mid reset", 64'(in_ready), 64'd1);

      // WIDTH=32: SRA 0x80000000 by 31, latency 5
      @(negedge clk);
      in_data32 = 32'h8000_0000; in_shamt32 = 5'd31; in_op32 = 2'b10; in_valid32 = 1'b1;
      @(posedge clk);
      #1 in_valid32 = 1'b0;
      lat = 1; seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid32) begin seen = 1; break; end
         @(posedge clk);
         lat++;
      end
      chk("w32 result seen", 64'(seen), 64'd1);
      chk("w32 latency", 64'(lat), 64'd5);
      chk("w32 data", 64'(out_data32), 64'hFFFF_FFFF);
      chk("w32 neg", 64'(out_neg32), 64'd1);
      chk("w32 zr", 64'(out_zr32), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
